// File: rtl/diag_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : diag_spi_slave
// Description : Oversampled SPI mode-0 slave giving the board MCU read/write
//               access to a 128 x 32-bit diagnostic register port.
//               Optional status echo during the command byte: DIAG_SPI_STATUS_EN
// Revision    : 1.0  initial release
// ============================================================================
module diag_spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_ss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [6:0]  reg_addr,
    output logic        reg_re,
    input  logic [31:0] reg_rdata,
    output logic        reg_we,
    output logic [31:0] reg_wdata,
    input  logic [7:0]  stat_in,
    output logic        busy,
    output logic        frame_abort
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RD   = 2'd2,
        S_WR   = 2'd3
    } state_t;

    localparam logic [4:0] c_CMD_LAST  = 5'd7;
    localparam logic [4:0] c_WORD_LAST = 5'd31;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   ss_filt_q;

    state_t                 state_q;
    logic [4:0]             bit_cnt_q;
    logic [30:0]            shift_in_q;
    logic [31:0]            shift_out_q;
    logic                   miso_q;
    logic [6:0]             addr_q;
    logic                   re_q;
    logic                   we_q;
    logic [31:0]            wdata_q;
    logic                   busy_q;
    logic                   abort_q;
    logic [RD_LATENCY-1:0]  rd_pipe_q;

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_mosi;
    logic w_ss_fall;
    logic w_ss_rise;
    logic w_rd_load;

    // SS resets to "low" so a frame already running at reset release is not
    // mistaken for a new one; SS only changes once every stage agrees.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_filt_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            if (&ss_sync_q) begin
                ss_filt_q <= 1'b1;
            end else if (~|ss_sync_q) begin
                ss_filt_q <= 1'b0;
            end
        end
    end

    assign w_sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign w_sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    assign w_mosi     = mosi_sync_q[SYNC_STAGES-1];
    assign w_ss_fall  = ss_filt_q & ~|ss_sync_q;
    assign w_ss_rise  = ~ss_filt_q & (&ss_sync_q);

    generate
        if (RD_LATENCY == 1) begin : g_rd_pipe_single
            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    rd_pipe_q <= '0;
                end else begin
                    rd_pipe_q <= re_q;
                end
            end
        end else begin : g_rd_pipe_multi
            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    rd_pipe_q <= '0;
                end else begin
                    rd_pipe_q <= {rd_pipe_q[RD_LATENCY-2:0], re_q};
                end
            end
        end
    endgenerate

    assign w_rd_load = rd_pipe_q[RD_LATENCY-1];

`ifndef DIAG_SPI_STATUS_EN
    logic unused_stat;
    assign unused_stat = ^stat_in;
`endif

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '1;
            miso_q      <= 1'b1;
            addr_q      <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            if (we_q) begin
                addr_q <= addr_q + 7'd1;
            end

            // SS release beats any SCK edge seen in the same cycle.
            if ((state_q != S_IDLE) && w_ss_rise) begin
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                miso_q    <= 1'b1;
                bit_cnt_q <= '0;
                if (((state_q == S_CMD) || (state_q == S_WR)) && (bit_cnt_q != 5'd0)) begin
                    abort_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (w_ss_fall) begin
                            state_q   <= S_CMD;
                            busy_q    <= 1'b1;
                            bit_cnt_q <= '0;
`ifdef DIAG_SPI_STATUS_EN
                            miso_q      <= stat_in[7];
                            shift_out_q <= {stat_in[6:0], 25'h1FF_FFFF};
`else
                            miso_q      <= 1'b1;
`endif
                        end
                    end
                    S_CMD: begin
                        if (w_sck_rise) begin
                            shift_in_q <= {shift_in_q[29:0], w_mosi};
                            if (bit_cnt_q == c_CMD_LAST) begin
                                bit_cnt_q <= '0;
                                addr_q    <= {shift_in_q[5:0], w_mosi};
                                miso_q    <= 1'b1;
                                if (shift_in_q[6]) begin
                                    re_q    <= 1'b1;
                                    state_q <= S_RD;
                                end else begin
                                    state_q <= S_WR;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
`ifdef DIAG_SPI_STATUS_EN
                        else if (w_sck_fall) begin
                            miso_q      <= shift_out_q[31];
                            shift_out_q <= {shift_out_q[30:0], 1'b1};
                        end
`endif
                    end
                    S_RD: begin
                        if (w_rd_load) begin
                            shift_out_q <= reg_rdata;
                        end else if (w_sck_fall) begin
                            miso_q      <= shift_out_q[31];
                            shift_out_q <= {shift_out_q[30:0], 1'b1};
                        end
                        if (w_sck_rise) begin
                            if (bit_cnt_q == c_WORD_LAST) begin
                                bit_cnt_q <= '0;
                                addr_q    <= addr_q + 7'd1;
                                re_q      <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    S_WR: begin
                        if (w_sck_rise) begin
                            shift_in_q <= {shift_in_q[29:0], w_mosi};
                            if (bit_cnt_q == c_WORD_LAST) begin
                                bit_cnt_q <= '0;
                                wdata_q   <= {shift_in_q, w_mosi};
                                we_q      <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign spi_miso    = miso_q;
    assign reg_addr    = addr_q;
    assign reg_re      = re_q;
    assign reg_we      = we_q;
    assign reg_wdata   = wdata_q;
    assign busy        = busy_q;
    assign frame_abort = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_diag_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_diag_spi_slave
// Description : Directed scoreboard bench for diag_spi_slave.
// Revision    : 1.0  initial release
// ============================================================================
module tb_diag_spi_slave;

    localparam int HALF = 8;
`ifdef DIAG_SPI_STATUS_EN
    localparam logic [7:0] c_STAT_EXP = 8'hA5;
`else
    localparam logic [7:0] c_STAT_EXP = 8'hFF;
`endif

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic [6:0]  reg_addr;
    logic        reg_re;
    logic [31:0] reg_rdata = '0;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [7:0]  stat_in;
    logic        busy;
    logic        frame_abort;

    int n_checks  = 0;
    int n_fail    = 0;
    int we_cnt    = 0;
    int re_cnt    = 0;
    int abort_cnt = 0;

    logic [38:0] exp_we_q[$];
    logic [6:0]  exp_re_q[$];

    diag_spi_slave #(
        .SYNC_STAGES(2),
        .RD_LATENCY (1)
    ) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .spi_sck    (spi_sck),
        .spi_ss     (spi_ss),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .reg_addr   (reg_addr),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_we     (reg_we),
        .reg_wdata  (reg_wdata),
        .stat_in    (stat_in),
        .busy       (busy),
        .frame_abort(frame_abort)
    );

    always #10 clk_50 = ~clk_50;

    // Register file model: data equals the address that was read.
    always @(posedge clk_50) begin
        if (reg_re) begin
            reg_rdata <= {25'b0, reg_addr};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_50) begin
        if (reset_n) begin
            if (reg_we) begin
                we_cnt++;
                check("re_we_exclusive", {63'b0, reg_re}, 64'd0);
                if (exp_we_q.size() == 0) begin
                    check("we_unexpected", {63'b0, reg_we}, 64'd0);
                end else begin
                    check("we_addr_data", {25'b0, reg_addr, reg_wdata}, {25'b0, exp_we_q.pop_front()});
                end
            end
            if (reg_re) begin
                re_cnt++;
                if (exp_re_q.size() == 0) begin
                    check("re_unexpected", {63'b0, reg_re}, 64'd0);
                end else begin
                    check("re_addr", {57'b0, reg_addr}, {57'b0, exp_re_q.pop_front()});
                end
            end
            if (frame_abort) begin
                abort_cnt++;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic spi_bit(input logic b, output logic miso_s);
        spi_mosi = b;
        wait_clk(HALF);
        miso_s   = spi_miso;
        spi_sck  = 1'b1;
        wait_clk(HALF);
        spi_sck  = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n, output logic [31:0] rx);
        logic m;
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(v[i], m);
            rx = {rx[30:0], m};
        end
    endtask

    task automatic frame_start();
        spi_ss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        spi_ss = 1'b1;
        wait_clk(2 * HALF);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        logic [31:0] rx2;
        logic        m;
        int          base;

        reset_n  = 1'b0;
        spi_sck  = 1'b0;
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        stat_in  = 8'hA5;
        wait_clk(5);
        check("rst_miso",  {63'b0, spi_miso}, 64'd1);
        check("rst_busy",  {63'b0, busy}, 64'd0);
        check("rst_re",    {63'b0, reg_re}, 64'd0);
        check("rst_we",    {63'b0, reg_we}, 64'd0);
        check("rst_abort", {63'b0, frame_abort}, 64'd0);
        check("rst_addr",  {57'b0, reg_addr}, 64'd0);
        check("rst_wdata", {32'b0, reg_wdata}, 64'd0);

        reset_n = 1'b1;
        wait_clk(100);
        check("idle_miso", {63'b0, spi_miso}, 64'd1);
        check("idle_busy", {63'b0, busy}, 64'd0);
        check("idle_no_strobes", 64'(we_cnt + re_cnt + abort_cnt), 64'd0);

        // One-cycle SS glitch must not open a frame
        spi_ss = 1'b0;
        wait_clk(1);
        spi_ss = 1'b1;
        wait_clk(10);
        check("glitch_busy", {63'b0, busy}, 64'd0);

        // Write two words starting at 0x05
        exp_we_q.push_back({7'h05, 32'hDEADBEEF});
        exp_we_q.push_back({7'h06, 32'h01234567});
        base = abort_cnt;
        frame_start();
        check("wr_busy", {63'b0, busy}, 64'd1);
        spi_bits(32'h05, 8, rx);
        spi_bits(32'hDEADBEEF, 32, rx);
        spi_bits(32'h01234567, 32, rx);
        frame_end();
        check("wr_busy_end", {63'b0, busy}, 64'd0);
        check("wr_all_seen", 64'(exp_we_q.size()), 64'd0);
        check("wr_no_abort", 64'(abort_cnt - base), 64'd0);
        check("wr_addr_after", {57'b0, reg_addr}, 64'h07);

        // Read two words starting at 0x01, status byte on MISO during command
        exp_re_q.push_back(7'h01);
        exp_re_q.push_back(7'h02);
        exp_re_q.push_back(7'h03);
        base = re_cnt;
        frame_start();
        spi_bits(32'h81, 8, rx);
        check("cmd_miso_status", {56'b0, rx[7:0]}, {56'b0, c_STAT_EXP});
        spi_bits(32'h0, 32, rx);
        check("rd_word0", {32'b0, rx}, 64'h1);
        spi_bits(32'h0, 31, rx2);
        check("rd_re_pulses", 64'(re_cnt - base), 64'd2);
        spi_bit(1'b0, m);
        rx2 = {rx2[30:0], m};
        check("rd_word1", {32'b0, rx2}, 64'h2);
        frame_end();
        check("rd_prefetch_seen", 64'(exp_re_q.size()), 64'd0);
        check("rd_miso_idle", {63'b0, spi_miso}, 64'd1);

        // Partial read word is not an abort
        exp_re_q.push_back(7'h01);
        base = abort_cnt;
        frame_start();
        spi_bits(32'h81, 8, rx);
        spi_bits(32'h0, 5, rx);
        frame_end();
        check("rdpart_no_abort", 64'(abort_cnt - base), 64'd0);
        check("rdpart_re_seen", 64'(exp_re_q.size()), 64'd0);
        check("rdpart_busy", {63'b0, busy}, 64'd0);

        // Address wrap 0x7F -> 0x00
        exp_we_q.push_back({7'h7F, 32'hCAFEF00D});
        exp_we_q.push_back({7'h00, 32'h13579BDF});
        frame_start();
        spi_bits(32'h7F, 8, rx);
        spi_bits(32'hCAFEF00D, 32, rx);
        spi_bits(32'h13579BDF, 32, rx);
        frame_end();
        check("wrap_all_seen", 64'(exp_we_q.size()), 64'd0);
        check("wrap_addr_after", {57'b0, reg_addr}, 64'h01);

        // Reset mid-frame; the rest of that frame is ignored
        base = we_cnt;
        frame_start();
        spi_bits(32'h03, 5, rx);
        reset_n = 1'b0;
        wait_clk(2);
        check("midrst_miso", {63'b0, spi_miso}, 64'd1);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_addr", {57'b0, reg_addr}, 64'd0);
        reset_n = 1'b1;
        wait_clk(4);
        spi_bits(32'h7, 3, rx);
        spi_bits(32'h12345678, 32, rx);
        check("midrst_ignored_busy", {63'b0, busy}, 64'd0);
        frame_end();
        check("midrst_no_we", 64'(we_cnt - base), 64'd0);

        // Abort during a write word, then a clean frame
        base = abort_cnt;
        frame_start();
        spi_bits(32'h10, 8, rx);
        spi_bits(32'hABC, 12, rx);
        frame_end();
        check("abort_once", 64'(abort_cnt - base), 64'd1);
        check("abort_no_we", 64'(exp_we_q.size()), 64'd0);
        exp_we_q.push_back({7'h20, 32'hA5A55A5A});
        frame_start();
        spi_bits(32'h20, 8, rx);
        spi_bits(32'hA5A55A5A, 32, rx);
        frame_end();
        check("post_abort_we", 64'(exp_we_q.size()), 64'd0);
        check("post_abort_clean", 64'(abort_cnt - base), 64'd1);

        // Abort during the command byte
        frame_start();
        spi_bits(32'h5, 3, rx);
        frame_end();
        check("cmd_abort", 64'(abort_cnt - base), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
